// File: rtl/vscale_xvec_alu_seq_pkg.sv
// Shared constants, state encoding and the per-element ALU function for the
// xvec multi-pass sequencer and its lane slice.
package vscale_xvec_alu_seq_pkg;

  localparam int XPR_LEN      = 32;
  localparam int SHAMT_WIDTH  = 5;
  localparam int ALU_OP_WIDTH = 4;
  localparam int XVEC_NELEM   = 32;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SEQ  = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SNE  = 4'd9;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'd10;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'd11;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'd12;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGE  = 4'd13;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'd14;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGEU = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Pass counter width; a single-pass configuration still keeps one bit.
  function automatic int pass_width(input int lanes);
    int npass;
    npass = XVEC_NELEM / lanes;
    return (npass > 1) ? $clog2(npass) : 1;
  endfunction

  function automatic logic [XPR_LEN-1:0] alu_elem(
    input logic [ALU_OP_WIDTH-1:0] op,
    input logic [SHAMT_WIDTH-1:0]  shamt,
    input logic [XPR_LEN-1:0]      a,
    input logic [XPR_LEN-1:0]      b
  );
    logic [XPR_LEN-1:0] r;
    case (op)
      ALU_OP_ADD:  r = a + b;
      ALU_OP_SUB:  r = a - b;
      ALU_OP_XOR:  r = a ^ b;
      ALU_OP_OR:   r = a | b;
      ALU_OP_AND:  r = a & b;
      ALU_OP_SLL:  r = a << shamt;
      ALU_OP_SRL:  r = a >> shamt;
      ALU_OP_SRA:  r = $unsigned($signed(a) >>> shamt);
      ALU_OP_SEQ:  r = {{(XPR_LEN-1){1'b0}}, a == b};
      ALU_OP_SNE:  r = {{(XPR_LEN-1){1'b0}}, a != b};
      ALU_OP_SLT:  r = {{(XPR_LEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_OP_SGE:  r = {{(XPR_LEN-1){1'b0}}, $signed(a) >= $signed(b)};
      ALU_OP_SLTU: r = {{(XPR_LEN-1){1'b0}}, a < b};
      ALU_OP_SGEU: r = {{(XPR_LEN-1){1'b0}}, a >= b};
      default:     r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vscale_xvec_alu_slice.sv
// Combinational LANES-wide ALU slice; every lane applies the same op and the
// same shift amount to its own pair of elements.
module vscale_xvec_alu_slice
  import vscale_xvec_alu_seq_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic [ALU_OP_WIDTH-1:0]  op,
  input  logic [SHAMT_WIDTH-1:0]   shamt,
  input  logic [LANES*XPR_LEN-1:0] a,
  input  logic [LANES*XPR_LEN-1:0] b,
  output logic [LANES*XPR_LEN-1:0] y
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign y[l*XPR_LEN +: XPR_LEN] =
      alu_elem(op, shamt, a[l*XPR_LEN +: XPR_LEN], b[l*XPR_LEN +: XPR_LEN]);
  end

endmodule

// File: rtl/vscale_xvec_alu_seq.sv
// Multi-pass sequencer: captures one 32-element op, feeds LANES elements per
// cycle through the slice, scatters results and holds them for the consumer.
module vscale_xvec_alu_seq
  import vscale_xvec_alu_seq_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [ALU_OP_WIDTH-1:0]         req_op,
  input  logic                            req_xvec_mode,
  input  logic [XVEC_NELEM*XPR_LEN-1:0]   req_in1,
  input  logic [XVEC_NELEM*XPR_LEN-1:0]   req_in2,
  input  logic                            kill,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [XVEC_NELEM*XPR_LEN-1:0]   resp_out,
  output logic                            busy
);

  localparam int NPASS   = XVEC_NELEM / LANES;
  localparam int PASS_W  = pass_width(LANES);
  localparam int VEC_W   = XVEC_NELEM * XPR_LEN;
  localparam int SLICE_W = LANES * XPR_LEN;
  localparam int IDX_W   = $clog2(VEC_W);

  state_e                  state_q, state_d;
  logic [PASS_W-1:0]       pass_q, pass_d;
  logic [ALU_OP_WIDTH-1:0] op_q, op_d;
  logic                    mode_q, mode_d;
  logic [VEC_W-1:0]        in1_q, in1_d;
  logic [VEC_W-1:0]        in2_q, in2_d;
  logic [VEC_W-1:0]        result_q, result_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    busy_q, busy_d;
  logic                    req_ready_q, req_ready_d;

  logic [IDX_W-1:0]        base;
  logic [SLICE_W-1:0]      slice_a, slice_b, slice_y, lane_mask;
  logic [PASS_W-1:0]       last_pass;

  // Operand mux: the current pass selects a contiguous LANES-element window.
  assign base      = IDX_W'(pass_q) * IDX_W'(SLICE_W);
  assign slice_a   = in1_q[base +: SLICE_W];
  assign slice_b   = in2_q[base +: SLICE_W];
  assign lane_mask = mode_q ? '1 : SLICE_W'({XPR_LEN{1'b1}});
  assign last_pass = mode_q ? PASS_W'(NPASS - 1) : '0;

  vscale_xvec_alu_slice #(
    .LANES (LANES)
  ) u_slice (
    .op    (op_q),
    .shamt (in2_q[SHAMT_WIDTH-1:0]),
    .a     (slice_a),
    .b     (slice_b),
    .y     (slice_y)
  );

  // resp_valid rises one cycle after DONE is entered and falls on the handshake.
  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    op_d     = op_q;
    mode_d   = mode_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !kill) begin
          op_d     = req_op;
          mode_d   = req_xvec_mode;
          in1_d    = req_in1;
          in2_d    = req_in2;
          result_d = '0;
          pass_d   = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        result_d[base +: SLICE_W] = slice_y & lane_mask;
        if (pass_q == last_pass) begin
          state_d = S_DONE;
        end else begin
          pass_d = pass_q + PASS_W'(1);
        end
      end
      S_DONE: begin
        if (resp_valid_q && resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (kill) begin
      state_d = S_IDLE;
      pass_d  = '0;
    end
    resp_valid_d = (state_q == S_DONE) && !kill && !(resp_valid_q && resp_ready);
    busy_d       = (state_d != S_IDLE);
    req_ready_d  = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pass_q       <= '0;
      op_q         <= '0;
      mode_q       <= 1'b0;
      in1_q        <= '0;
      in2_q        <= '0;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      pass_q       <= pass_d;
      op_q         <= op_d;
      mode_q       <= mode_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign busy       = busy_q;
  assign resp_out   = result_q;

endmodule
